bcd_updown_display_counter: RTL and testbench

Parametrised two-digit BCD counter driving both 7-segment displays directly. It counts up or down between 0 and a configurable MAX_COUNT at a configurable tick rate. It supports run/pause, synchronous clear, parallel BCD load, leading-zero blanking and a wrap strobe. It replaces the fixed 00-99 up-counter as the top-level display engine and is fed by the debounced switch logic.

---
 rtl/bcd_updown_display_counter.sv | 173 +++++++++++++++++
 tb/tb_bcd_updown_display_counter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_display_counter.sv
// Two-digit BCD up/down counter with run/pause control, clear, parallel load,
// wrap strobe and direct drive of two 7-segment displays.
module bcd_updown_display_counter #(
  parameter int TICK_CYCLES        = 12_500_000,
  parameter int MAX_COUNT          = 99,
  parameter bit BLANK_LEADING_ZERO = 1'b1,
  parameter bit ACTIVE_LOW         = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start_Stop,
  input  logic       i_Up,
  input  logic       i_Clear,
  input  logic       i_Load,
  input  logic [3:0] i_Load_Tens,
  input  logic [3:0] i_Load_Units,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Units,
  output logic       o_Running,
  output logic       o_Wrap,
  output logic       o_Load_Error,
  output logic       o_Segment1_A,
  output logic       o_Segment1_B,
  output logic       o_Segment1_C,
  output logic       o_Segment1_D,
  output logic       o_Segment1_E,
  output logic       o_Segment1_F,
  output logic       o_Segment1_G,
  output logic       o_Segment2_A,
  output logic       o_Segment2_B,
  output logic       o_Segment2_C,
  output logic       o_Segment2_D,
  output logic       o_Segment2_E,
  output logic       o_Segment2_F,
  output logic       o_Segment2_G
);

  localparam int            TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  // Terminal value split into digits at elaboration time; no runtime division.
  localparam logic [3:0]    MAX_TENS  = 4'(MAX_COUNT / 10);
  localparam logic [3:0]    MAX_UNITS = 4'(MAX_COUNT % 10);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  state_t        r_State, w_Next_State;
  logic [TW-1:0] r_Tick_Count;
  logic [3:0]    r_Tens, r_Units;
  logic [3:0]    w_Next_Tens, w_Next_Units;
  logic          r_Wrap, r_Load_Error;
  logic          w_Next_Wrap, w_Next_Load_Error;
  logic          w_Tick, w_Load_Ok, w_At_Max, w_At_Zero;
  logic [6:0]    w_Tens_Pat, w_Units_Pat, w_Seg1, w_Seg2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_State <= PAUSE;
    else         r_State <= w_Next_State;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_Next_State = r_State;
    if (i_Start_Stop) w_Next_State = (r_State == RUN) ? PAUSE : RUN;
  end

  assign w_Tick = (r_State == RUN) && (r_Tick_Count == TICK_LAST);

  // Prescaler freezes in PAUSE so a resumed run finishes the current period.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) r_Tick_Count <= '0;
    else if (r_State == RUN) r_Tick_Count <= w_Tick ? '0 : r_Tick_Count + TW'(1);
  end

  // Both inputs are BCD here, so a digit-wise lexicographic compare is exact.
  assign w_Load_Ok = (i_Load_Tens <= 4'd9) && (i_Load_Units <= 4'd9) &&
                     ((i_Load_Tens < MAX_TENS) ||
                      ((i_Load_Tens == MAX_TENS) && (i_Load_Units <= MAX_UNITS)));
  assign w_At_Max  = (r_Tens == MAX_TENS) && (r_Units == MAX_UNITS);
  assign w_At_Zero = (r_Tens == 4'd0) && (r_Units == 4'd0);

  always_comb begin
    w_Next_Tens       = r_Tens;
    w_Next_Units      = r_Units;
    w_Next_Wrap       = 1'b0;
    w_Next_Load_Error = 1'b0;
    if (i_Clear) begin
      w_Next_Tens  = 4'd0;
      w_Next_Units = 4'd0;
    end else if (i_Load) begin
      if (w_Load_Ok) begin
        w_Next_Tens  = i_Load_Tens;
        w_Next_Units = i_Load_Units;
      end else begin
        w_Next_Load_Error = 1'b1;
      end
    end else if (w_Tick) begin
      if (i_Up) begin
        if (w_At_Max) begin
          w_Next_Tens  = 4'd0;
          w_Next_Units = 4'd0;
          w_Next_Wrap  = 1'b1;
        end else if (r_Units == 4'd9) begin
          w_Next_Units = 4'd0;
          w_Next_Tens  = r_Tens + 4'd1;
        end else begin
          w_Next_Units = r_Units + 4'd1;
        end
      end else begin
        if (w_At_Zero) begin
          w_Next_Tens  = MAX_TENS;
          w_Next_Units = MAX_UNITS;
          w_Next_Wrap  = 1'b1;
        end else if (r_Units == 4'd0) begin
          w_Next_Units = 4'd9;
          w_Next_Tens  = r_Tens - 4'd1;
        end else begin
          w_Next_Units = r_Units - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Tens       <= 4'd0;
      r_Units      <= 4'd0;
      r_Wrap       <= 1'b0;
      r_Load_Error <= 1'b0;
    end else begin
      r_Tens       <= w_Next_Tens;
      r_Units      <= w_Next_Units;
      r_Wrap       <= w_Next_Wrap;
      r_Load_Error <= w_Next_Load_Error;
    end
  end

  // Active-high pattern in {G,F,E,D,C,B,A} order; non-BCD codes are dark.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign w_Tens_Pat  = (BLANK_LEADING_ZERO && (r_Tens == 4'd0)) ? 7'b0000000 : seg7(r_Tens);
  assign w_Units_Pat = seg7(r_Units);
  assign w_Seg1      = ACTIVE_LOW ? ~w_Tens_Pat  : w_Tens_Pat;
  assign w_Seg2      = ACTIVE_LOW ? ~w_Units_Pat : w_Units_Pat;

  assign {o_Segment1_G, o_Segment1_F, o_Segment1_E, o_Segment1_D,
          o_Segment1_C, o_Segment1_B, o_Segment1_A} = w_Seg1;
  assign {o_Segment2_G, o_Segment2_F, o_Segment2_E, o_Segment2_D,
          o_Segment2_C, o_Segment2_B, o_Segment2_A} = w_Seg2;

  assign o_Tens       = r_Tens;
  assign o_Units      = r_Units;
  assign o_Running    = (r_State == RUN);
  assign o_Wrap       = r_Wrap;
  assign o_Load_Error = r_Load_Error;

endmodule

// File: tb/tb_bcd_updown_display_counter.sv
// Bench for bcd_updown_display_counter: two configurations share one stimulus
// stream and are compared every cycle against an integer-count model.
module tb_bcd_updown_display_counter;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b0, up = 1'b0, clr = 1'b0, ld = 1'b0;
  logic [3:0] lt = 4'd0, lu = 4'd0;

  wire [3:0] a_tens, a_units, b_tens, b_units;
  wire       a_run, a_wrap, a_lerr, b_run, b_wrap, b_lerr;
  wire [6:0] a_s1, a_s2, b_s1, b_s2;

  always #5 clk = ~clk;

  // Instance a: MAX 99, active-low, leading-zero blanking.
  bcd_updown_display_counter #(
    .TICK_CYCLES(TICK), .MAX_COUNT(99), .BLANK_LEADING_ZERO(1'b1), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Start_Stop(ss), .i_Up(up), .i_Clear(clr),
    .i_Load(ld), .i_Load_Tens(lt), .i_Load_Units(lu),
    .o_Tens(a_tens), .o_Units(a_units), .o_Running(a_run), .o_Wrap(a_wrap),
    .o_Load_Error(a_lerr),
    .o_Segment1_A(a_s1[0]), .o_Segment1_B(a_s1[1]), .o_Segment1_C(a_s1[2]),
    .o_Segment1_D(a_s1[3]), .o_Segment1_E(a_s1[4]), .o_Segment1_F(a_s1[5]),
    .o_Segment1_G(a_s1[6]),
    .o_Segment2_A(a_s2[0]), .o_Segment2_B(a_s2[1]), .o_Segment2_C(a_s2[2]),
    .o_Segment2_D(a_s2[3]), .o_Segment2_E(a_s2[4]), .o_Segment2_F(a_s2[5]),
    .o_Segment2_G(a_s2[6])
  );

  // Instance b: MAX 59, active-high, no blanking.
  bcd_updown_display_counter #(
    .TICK_CYCLES(TICK), .MAX_COUNT(59), .BLANK_LEADING_ZERO(1'b0), .ACTIVE_LOW(1'b0)
  ) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Start_Stop(ss), .i_Up(up), .i_Clear(clr),
    .i_Load(ld), .i_Load_Tens(lt), .i_Load_Units(lu),
    .o_Tens(b_tens), .o_Units(b_units), .o_Running(b_run), .o_Wrap(b_wrap),
    .o_Load_Error(b_lerr),
    .o_Segment1_A(b_s1[0]), .o_Segment1_B(b_s1[1]), .o_Segment1_C(b_s1[2]),
    .o_Segment1_D(b_s1[3]), .o_Segment1_E(b_s1[4]), .o_Segment1_F(b_s1[5]),
    .o_Segment1_G(b_s1[6]),
    .o_Segment2_A(b_s2[0]), .o_Segment2_B(b_s2[1]), .o_Segment2_C(b_s2[2]),
    .o_Segment2_D(b_s2[3]), .o_Segment2_E(b_s2[4]), .o_Segment2_F(b_s2[5]),
    .o_Segment2_G(b_s2[6])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] pat [10];
  int  max_c [2] = '{99, 59};
  bit  al    [2] = '{1'b1, 1'b0};
  bit  blz   [2] = '{1'b1, 1'b0};
  int  m_cnt [2];
  int  m_pre [2];
  bit  m_run [2];
  bit  m_wrap[2];
  bit  m_lerr[2];
  bit  m_valid = 1'b0;

  initial begin
    pat[0] = 7'b0111111; pat[1] = 7'b0000110; pat[2] = 7'b1011011;
    pat[3] = 7'b1001111; pat[4] = 7'b1100110; pat[5] = 7'b1101101;
    pat[6] = 7'b1111101; pat[7] = 7'b0000111; pat[8] = 7'b1111111;
    pat[9] = 7'b1101111;
  end

  function automatic logic [6:0] exp_seg(input int d, input bit blank_zero, input bit act_low);
    logic [6:0] p;
    p = (blank_zero && d == 0) ? 7'b0000000 : pat[d];
    return act_low ? ~p : p;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_run[i] = 1'b0;
        m_wrap[i] = 1'b0; m_lerr[i] = 1'b0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        bit tick;
        int lv;
        tick = m_run[i] && (m_pre[i] == TICK - 1);
        m_wrap[i] = 1'b0;
        m_lerr[i] = 1'b0;
        if (clr) begin
          m_cnt[i] = 0;
          m_pre[i] = 0;
        end else begin
          lv = int'(lt) * 10 + int'(lu);
          if (ld) begin
            if (lt <= 4'd9 && lu <= 4'd9 && lv <= max_c[i]) m_cnt[i] = lv;
            else m_lerr[i] = 1'b1;
          end else if (tick) begin
            if (up) begin
              if (m_cnt[i] == max_c[i]) begin m_cnt[i] = 0; m_wrap[i] = 1'b1; end
              else m_cnt[i] = m_cnt[i] + 1;
            end else begin
              if (m_cnt[i] == 0) begin m_cnt[i] = max_c[i]; m_wrap[i] = 1'b1; end
              else m_cnt[i] = m_cnt[i] - 1;
            end
          end
          if (m_run[i]) m_pre[i] = (m_pre[i] + 1) % TICK;
        end
        if (ss) m_run[i] = !m_run[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] tn, un;
        logic       rn, wr, le;
        logic [6:0] s1, s2;
        string      p;
        if (i == 0) begin
          tn = a_tens; un = a_units; rn = a_run; wr = a_wrap; le = a_lerr; s1 = a_s1; s2 = a_s2;
          p = "a";
        end else begin
          tn = b_tens; un = b_units; rn = b_run; wr = b_wrap; le = b_lerr; s1 = b_s1; s2 = b_s2;
          p = "b";
        end
        check({p, ".tens"},    32'(tn), 32'(m_cnt[i] / 10));
        check({p, ".units"},   32'(un), 32'(m_cnt[i] % 10));
        check({p, ".running"}, 32'(rn), 32'(m_run[i]));
        check({p, ".wrap"},    32'(wr), 32'(m_wrap[i]));
        check({p, ".load_err"},32'(le), 32'(m_lerr[i]));
        check({p, ".seg1"},    32'(s1), 32'(exp_seg(m_cnt[i] / 10, blz[i], al[i])));
        check({p, ".seg2"},    32'(s2), 32'(exp_seg(m_cnt[i] % 10, 1'b0, al[i])));
      end
    end
  end

  // Counts dut_a wrap pulses inside the 400-cycle up-count window.
  bit count_wraps = 1'b0;
  int wrap_a_cnt  = 0;
  always @(negedge clk) if (count_wraps && a_wrap === 1'b1) wrap_a_cnt++;

  // Inputs change 2 time units after a rising edge, so the next edge samples them.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic lit_a(input string name, input int t, input int u);
    check({name, ".a_tens"},  32'(a_tens),  32'(t));
    check({name, ".a_units"}, 32'(a_units), 32'(u));
  endtask

  task automatic lit_b(input string name, input int t, input int u);
    check({name, ".b_tens"},  32'(b_tens),  32'(t));
    check({name, ".b_units"}, 32'(b_units), 32'(u));
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    // Reset state, hand values.
    lit_a("reset", 0, 0);
    check("reset.a_seg1", 32'(a_s1), 32'h7F);
    check("reset.a_seg2", 32'(a_s2), 32'b1000000);
    check("reset.b_seg1", 32'(b_s1), 32'b0111111);
    check("reset.a_running", 32'(a_run), 0);

    // Up count 00 -> 99 -> 00 over 400 cycles.
    up = 1'b1; ss = 1'b1; step(1); ss = 1'b0;
    check("start.a_running", 32'(a_run), 1);
    count_wraps = 1'b1;
    step(3);
    lit_a("pre_first_step", 0, 0);
    step(1);
    lit_a("first_step", 0, 1);
    step(396);
    lit_a("step100", 0, 0);
    check("step100.a_wrap", 32'(a_wrap), 1);
    step(1);
    count_wraps = 1'b0;
    check("wrap_once", 32'(wrap_a_cnt), 1);

    // Pause at 37 with prescaler 2, then resume.
    step(148);
    lit_a("before_pause", 3, 7);
    ss = 1'b1; step(1); ss = 1'b0;
    step(50);
    lit_a("paused", 3, 7);
    check("paused.a_running", 32'(a_run), 0);
    ss = 1'b1; step(1); ss = 1'b0;
    step(1);
    lit_a("resume+1", 3, 7);
    step(1);
    lit_a("resume+2", 3, 8);

    // Reset mid-run at 73 with other inputs active.
    step(140);
    lit_a("at73", 7, 3);
    rst = 1'b1; ss = 1'b1; ld = 1'b1; lt = 4'd1; lu = 4'd1;
    step(1);
    rst = 1'b0; ss = 1'b0; ld = 1'b0;
    lit_a("midrun_reset", 0, 0);
    check("midrun_reset.a_running", 32'(a_run), 0);
    check("midrun_reset.a_seg1", 32'(a_s1), 32'h7F);
    check("midrun_reset.a_seg2", 32'(a_s2), 32'b1000000);

    // Down count from 00.
    up = 1'b0; ss = 1'b1; step(1); ss = 1'b0;
    step(4);
    lit_b("down1", 5, 9);
    check("down1.b_wrap", 32'(b_wrap), 1);
    lit_a("down1", 9, 9);
    step(4);
    lit_b("down2", 5, 8);
    step(4);
    lit_b("down3", 5, 7);

    // Loads: accepted, rejected by MAX_COUNT, rejected as non-BCD.
    ld = 1'b1; lt = 4'd4; lu = 4'd2; step(1);
    lit_b("load42", 4, 2);
    lit_a("load42", 4, 2);
    lt = 4'd6; lu = 4'd0; step(1);
    check("load60.b_err", 32'(b_lerr), 1);
    lit_b("load60", 4, 2);
    lit_a("load60", 6, 0);
    lt = 4'd10; lu = 4'd0; step(1);
    check("loadA0.a_err", 32'(a_lerr), 1);
    lit_a("loadA0", 6, 0);

    // Clear and load together on a tick edge.
    clr = 1'b1; lt = 4'd4; lu = 4'd2; step(1);
    clr = 1'b0; ld = 1'b0;
    lit_a("clear_on_tick", 0, 0);
    check("clear_on_tick.a_err", 32'(a_lerr), 0);

    // Load alone on a tick edge, then direction change.
    step(3);
    ld = 1'b1; lt = 4'd1; lu = 4'd5; step(1); ld = 1'b0;
    lit_a("load_on_tick", 1, 5);
    up = 1'b1; step(4);
    lit_a("after_up", 1, 6);

    // Clear while paused restarts a full prescaler period.
    ss = 1'b1; step(1); ss = 1'b0;
    clr = 1'b1; step(1); clr = 1'b0;
    ss = 1'b1; step(1); ss = 1'b0;
    step(3);
    lit_a("clr_pause+3", 0, 0);
    step(1);
    lit_a("clr_pause+4", 0, 1);

    // Borrow through a tens boundary.
    up = 1'b0; ld = 1'b1; lt = 4'd2; lu = 4'd0; step(1); ld = 1'b0;
    step(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
